// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sequencer
// Brief    : Host command sequencer: control pulses, timed software reset,
//            32-bit sample-count loader and per-command acknowledge byte.
// Revision : 1.0
// ============================================================================
module cmd_sequencer #(
    parameter int unsigned SAMPLE_BYTES    = 4,
    parameter logic [31:0] DEFAULT_SAMPLES = 32'd1000000,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd5000000,
    parameter logic [7:0]  RESET_HOLD      = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  Byte_in,
    input  logic        dec_start,
    input  logic        dec_connect,
    input  logic        dec_sw_reset,
    input  logic        dec_set_samples,
    output logic        start_pulse,
    output logic        connect_pulse,
    output logic        sw_reset_out,
    output logic [31:0] sample_count,
    output logic        samples_loaded,
    output logic        cmd_error,
    output logic        busy,
    output logic        ack_valid,
    output logic [7:0]  ack_byte,
    input  logic        ack_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ACK     = 2'd2,
        RSTHOLD = 2'd3
    } state_t;

    localparam logic [7:0]  CHAR_START   = 8'd115;
    localparam logic [7:0]  CHAR_CONNECT = 8'd99;
    localparam logic [7:0]  CHAR_SAMPLES = 8'd116;
    localparam logic [7:0]  LAST_BYTE    = 8'(SAMPLE_BYTES - 1);
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [7:0]  HOLD_LAST    = RESET_HOLD - 8'd1;

    state_t      state, state_nxt;
    logic [31:0] shreg, shreg_nxt, shreg_shifted;
    logic [7:0]  byte_cnt, byte_cnt_nxt;
    logic [23:0] timeout_cnt, timeout_cnt_nxt, timeout_inc;
    logic [7:0]  hold_cnt, hold_cnt_nxt;
    logic [31:0] sample_count_nxt;
    logic [7:0]  ack_byte_nxt;
    logic        ack_valid_nxt;
    logic        start_nxt, connect_nxt, loaded_nxt, error_nxt, sw_reset_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            byte_cnt       <= '0;
            timeout_cnt    <= '0;
            hold_cnt       <= '0;
            sample_count   <= DEFAULT_SAMPLES;
            ack_byte       <= '0;
            ack_valid      <= 1'b0;
            start_pulse    <= 1'b0;
            connect_pulse  <= 1'b0;
            samples_loaded <= 1'b0;
            cmd_error      <= 1'b0;
            sw_reset_out   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            shreg          <= shreg_nxt;
            byte_cnt       <= byte_cnt_nxt;
            timeout_cnt    <= timeout_cnt_nxt;
            hold_cnt       <= hold_cnt_nxt;
            sample_count   <= sample_count_nxt;
            ack_byte       <= ack_byte_nxt;
            ack_valid      <= ack_valid_nxt;
            start_pulse    <= start_nxt;
            connect_pulse  <= connect_nxt;
            samples_loaded <= loaded_nxt;
            cmd_error      <= error_nxt;
            sw_reset_out   <= sw_reset_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt        = state;
        shreg_nxt        = shreg;
        byte_cnt_nxt     = byte_cnt;
        timeout_cnt_nxt  = timeout_cnt;
        hold_cnt_nxt     = hold_cnt;
        sample_count_nxt = sample_count;
        ack_byte_nxt     = ack_byte;
        ack_valid_nxt    = ack_valid;
        start_nxt        = 1'b0;
        connect_nxt      = 1'b0;
        loaded_nxt       = 1'b0;
        error_nxt        = 1'b0;
        sw_reset_nxt     = sw_reset_out;
        shreg_shifted    = {shreg[23:0], Byte_in};
        timeout_inc      = timeout_cnt + 24'd1;

        case (state)
            IDLE: begin
                if (byte_valid) begin
                    if (dec_start) begin
                        start_nxt     = 1'b1;
                        ack_byte_nxt  = CHAR_START;
                        ack_valid_nxt = 1'b1;
                        state_nxt     = ACK;
                    end else if (dec_connect) begin
                        connect_nxt   = 1'b1;
                        ack_byte_nxt  = CHAR_CONNECT;
                        ack_valid_nxt = 1'b1;
                        state_nxt     = ACK;
                    end else if (dec_set_samples) begin
                        shreg_nxt       = '0;
                        byte_cnt_nxt    = '0;
                        timeout_cnt_nxt = '0;
                        state_nxt       = COLLECT;
                    end else if (dec_sw_reset) begin
                        sw_reset_nxt = 1'b1;
                        hold_cnt_nxt = '0;
                        state_nxt    = RSTHOLD;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end

            // Decoder strobes are deliberately ignored here: every byte is data.
            COLLECT: begin
                if (byte_valid) begin
                    shreg_nxt       = shreg_shifted;
                    timeout_cnt_nxt = '0;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_nxt     = '0;
                        sample_count_nxt = shreg_shifted;
                        loaded_nxt       = 1'b1;
                        ack_byte_nxt     = CHAR_SAMPLES;
                        ack_valid_nxt    = 1'b1;
                        state_nxt        = ACK;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 8'd1;
                    end
                end else if (timeout_inc == TIMEOUT_LAST) begin
                    timeout_cnt_nxt = '0;
                    byte_cnt_nxt    = '0;
                    error_nxt       = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    timeout_cnt_nxt = timeout_inc;
                end
            end

            ACK: begin
                if (ack_ready) begin
                    ack_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            RSTHOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt_nxt     = '0;
                    sample_count_nxt = DEFAULT_SAMPLES;
                    sw_reset_nxt     = 1'b0;
                    state_nxt        = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// Bench for cmd_sequencer: vector table, directed multi-cycle sequences and
// random command traffic checked against a command-level reference model.
module tb_cmd_sequencer;

    localparam logic [31:0] DEF = 32'd1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  Byte_in = 8'd0;
    logic        dec_start = 1'b0, dec_connect = 1'b0;
    logic        dec_sw_reset = 1'b0, dec_set_samples = 1'b0;
    logic        ack_ready = 1'b1;
    logic        start_pulse, connect_pulse, sw_reset_out, samples_loaded;
    logic        cmd_error, busy, ack_valid;
    logic [31:0] sample_count;
    logic [7:0]  ack_byte;

    always #5 clk = ~clk;

    cmd_sequencer #(
        .SAMPLE_BYTES    (4),
        .DEFAULT_SAMPLES (DEF),
        .TIMEOUT_CYCLES  (24'd100),
        .RESET_HOLD      (8'd16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .byte_valid      (byte_valid),
        .Byte_in         (Byte_in),
        .dec_start       (dec_start),
        .dec_connect     (dec_connect),
        .dec_sw_reset    (dec_sw_reset),
        .dec_set_samples (dec_set_samples),
        .start_pulse     (start_pulse),
        .connect_pulse   (connect_pulse),
        .sw_reset_out    (sw_reset_out),
        .sample_count    (sample_count),
        .samples_loaded  (samples_loaded),
        .cmd_error       (cmd_error),
        .busy            (busy),
        .ack_valid       (ack_valid),
        .ack_byte        (ack_byte),
        .ack_ready       (ack_ready)
    );

    int total = 0;
    int bad   = 0;

    // Passive event counters, sampled mid-cycle.
    int         n_start = 0, n_conn = 0, n_loaded = 0, n_err = 0, n_swr = 0, n_ack = 0;
    logic [7:0] last_ack = 8'd0;
    always @(negedge clk) begin
        if (start_pulse)    n_start++;
        if (connect_pulse)  n_conn++;
        if (samples_loaded) n_loaded++;
        if (cmd_error)      n_err++;
        if (sw_reset_out)   n_swr++;
        if (ack_valid && ack_ready) begin
            n_ack++;
            last_ack = ack_byte;
        end
    end

    typedef struct {
        logic [7:0] b;
        logic [4:0] pulses;      // {start, connect, error, sw_reset, ack_valid}
        logic [7:0] ack;
        int         busy_cycles;
    } vec_t;
    vec_t vecs[6];

    int s_start, s_conn, s_loaded, s_err, s_swr, s_ack;
    int n, stable, kind, dly;
    logic [31:0] model_count, data;
    logic [7:0]  exp_ack, rb;
    int          exp_start, exp_conn, exp_loaded, exp_err, exp_swr, exp_nack;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // The upstream decoder asserts its strobe for the matching character
    // regardless of sequencer state.
    task automatic send_byte(input logic [7:0] b);
        Byte_in         = b;
        byte_valid      = 1'b1;
        dec_start       = (b == 8'd115);
        dec_connect     = (b == 8'd99);
        dec_sw_reset    = (b == 8'd114);
        dec_set_samples = (b == 8'd116);
        tick();
        byte_valid      = 1'b0;
        dec_start       = 1'b0;
        dec_connect     = 1'b0;
        dec_sw_reset    = 1'b0;
        dec_set_samples = 1'b0;
        Byte_in         = 8'd0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic load_samples(input logic [31:0] v, input int maxgap);
        logic [31:0] sh;
        sh = v;
        send_byte(8'd116);
        for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, maxgap)) tick();
            send_byte(sh[31:24]);
            sh = sh << 8;
        end
    endtask

    task automatic snap();
        s_start = n_start; s_conn = n_conn; s_loaded = n_loaded;
        s_err = n_err; s_swr = n_swr; s_ack = n_ack;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{b: 8'd115, pulses: 5'b10001, ack: 8'd115, busy_cycles: 1};
        vecs[1] = '{b: 8'd99,  pulses: 5'b01001, ack: 8'd99,  busy_cycles: 1};
        vecs[2] = '{b: 8'h41,  pulses: 5'b00100, ack: 8'd0,   busy_cycles: 0};
        vecs[3] = '{b: 8'h00,  pulses: 5'b00100, ack: 8'd0,   busy_cycles: 0};
        vecs[4] = '{b: 8'hFF,  pulses: 5'b00100, ack: 8'd0,   busy_cycles: 0};
        vecs[5] = '{b: 8'd114, pulses: 5'b00010, ack: 8'd0,   busy_cycles: 16};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {start_pulse, connect_pulse, sw_reset_out, samples_loaded,
                           cmd_error, busy, ack_valid, ack_byte}, 0);
        check("rst_count", sample_count, DEF);
        reset = 1'b0;
        tick();

        // Single-byte IDLE commands
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].b);
            check($sformatf("vec%0d_pulses", i),
                  {start_pulse, connect_pulse, cmd_error, sw_reset_out, ack_valid}, vecs[i].pulses);
            if (vecs[i].pulses[0]) check($sformatf("vec%0d_ackbyte", i), ack_byte, vecs[i].ack);
            n = 0;
            while (busy && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("vec%0d_busy_len", i), n, vecs[i].busy_cycles);
            tick();
        end

        // Load 100000 with random gaps
        snap();
        load_samples(32'd100000, 10);
        check("ld1_pulse", samples_loaded, 1);
        check("ld1_ack", {ack_valid, ack_byte}, {1'b1, 8'd116});
        wait_idle("ld1_idle", 20);
        check("ld1_count", sample_count, 32'd100000);
        check("ld1_nloaded", n_loaded - s_loaded, 1);

        // Command characters as data
        snap();
        load_samples(32'h73637274, 3);
        wait_idle("ld2_idle", 20);
        check("ld2_count", sample_count, 32'h73637274);
        check("ld2_no_ctrl", (n_start - s_start) + (n_conn - s_conn) + (n_swr - s_swr) + (n_err - s_err), 0);
        check("ld2_ack", last_ack, 8'd116);

        // COLLECT timeout
        snap();
        send_byte(8'd116);
        send_byte(8'h12);
        send_byte(8'h34);
        n = 1;
        while (!cmd_error && n < 150) begin
            tick();
            n++;
        end
        check("tmo_latency", n, 100);
        check("tmo_busy", busy, 0);
        check("tmo_count", sample_count, 32'h73637274);
        tick();
        check("tmo_single", n_err - s_err, 1);
        check("tmo_noack", n_ack - s_ack, 0);

        // Byte arriving on the timeout-limit cycle wins
        snap();
        send_byte(8'd116);
        repeat (98) tick();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_idle("lim_idle", 20);
        check("lim_count", sample_count, 32'h01020304);
        check("lim_noerr", n_err - s_err, 0);

        // Software reset with bytes during the hold
        load_samples(32'd5000, 2);
        wait_idle("swr_ld_idle", 20);
        check("swr_pre_count", sample_count, 32'd5000);
        snap();
        send_byte(8'd114);
        check("swr_hi", sw_reset_out, 1);
        tick();
        tick();
        send_byte(8'd115);
        send_byte(8'd99);
        send_byte(8'd116);
        check("swr_hold_count", sample_count, 32'd5000);
        wait_idle("swr_idle", 40);
        tick();
        check("swr_len", n_swr - s_swr, 16);
        check("swr_ignored", (n_start - s_start) + (n_conn - s_conn) + (n_ack - s_ack) + (n_loaded - s_loaded), 0);
        check("swr_default", sample_count, DEF);
        check("swr_still_idle", busy, 0);

        // Ack backpressure
        snap();
        ack_ready = 1'b0;
        send_byte(8'd99);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack_valid && ack_byte == 8'd99) stable++;
            if (i == 3)       send_byte(8'd115);
            else if (i == 7)  send_byte(8'h41);
            else if (i == 11) send_byte(8'd116);
            else              tick();
        end
        check("bp_stable", stable, 20);
        ack_ready = 1'b1;
        tick();
        check("bp_release", {busy, ack_valid}, 0);
        check("bp_conn", n_conn - s_conn, 1);
        check("bp_dropped", (n_start - s_start) + (n_err - s_err), 0);
        check("bp_nack", n_ack - s_ack, 1);

        // Asynchronous reset mid-load
        load_samples(32'h0BADF00D, 0);
        wait_idle("mid_ld_idle", 20);
        send_byte(8'd116);
        send_byte(8'h11);
        send_byte(8'h22);
        check("mid_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_outs", {start_pulse, connect_pulse, sw_reset_out, samples_loaded,
                               cmd_error, busy, ack_valid, ack_byte}, 0);
        check("mid_rst_count", sample_count, DEF);
        tick();
        reset = 1'b0;
        tick();
        snap();
        send_byte(8'd99);
        check("mid_c_pulse", {connect_pulse, ack_valid, ack_byte}, {1'b1, 1'b1, 8'd99});
        wait_idle("mid_c_idle", 10);
        check("mid_c_count", sample_count, DEF);

        // Random command traffic against a command-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        model_count = DEF;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            dly  = $urandom_range(0, 4);
            exp_start = 0; exp_conn = 0; exp_loaded = 0; exp_err = 0; exp_swr = 0; exp_nack = 0;
            exp_ack = 8'd0;
            snap();
            ack_ready = (dly == 0);
            case (kind)
                0: begin
                    send_byte(8'd115);
                    exp_start = 1; exp_nack = 1; exp_ack = 8'd115;
                end
                1: begin
                    send_byte(8'd99);
                    exp_conn = 1; exp_nack = 1; exp_ack = 8'd99;
                end
                2: begin
                    data = $urandom;
                    load_samples(data, 10);
                    model_count = data;
                    exp_loaded = 1; exp_nack = 1; exp_ack = 8'd116;
                end
                3: begin
                    send_byte(8'd114);
                    model_count = DEF;
                    exp_swr = 16;
                end
                default: begin
                    rb = 8'(($urandom_range(0, 255)));
                    while (rb == 8'd99 || rb == 8'd114 || rb == 8'd115 || rb == 8'd116)
                        rb = 8'(($urandom_range(0, 255)));
                    send_byte(rb);
                    exp_err = 1;
                end
            endcase
            if (kind <= 2 && dly > 0) begin
                send_byte(8'(($urandom_range(0, 255))));
                repeat (dly - 1) tick();
            end
            ack_ready = 1'b1;
            wait_idle($sformatf("rnd%0d_idle", i), 60);
            tick();
            check($sformatf("rnd%0d_count", i), sample_count, model_count);
            check($sformatf("rnd%0d_pulses", i),
                  {8'(n_start - s_start), 8'(n_conn - s_conn), 8'(n_loaded - s_loaded), 8'(n_err - s_err)},
                  {8'(exp_start), 8'(exp_conn), 8'(exp_loaded), 8'(exp_err)});
            check($sformatf("rnd%0d_swr", i), n_swr - s_swr, exp_swr);
            check($sformatf("rnd%0d_nack", i), n_ack - s_ack, exp_nack);
            if (exp_nack != 0) check($sformatf("rnd%0d_ackbyte", i), last_ack, exp_ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
